// File: rtl/mem_bus_bridge.sv
// CPU memory-strobe to req/ack bus bridge: posted one-entry writes, stalled reads
// returned on the shared result bus, and a watchdog that aborts hung transfers.
module mem_bus_bridge #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  inout  tri   [31:0]           result_bus,
  output logic                  mem_wait,
  output logic                  bus_err,
  input  logic                  err_clr,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic [31:0]           ext_wdata,
  input  logic [31:0]           ext_rdata,
  input  logic                  ext_ack
);

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;

  state_t          state;
  logic [31:0]     rdata;
  logic [WD_W-1:0] wd_cnt;
  logic            in_xfer;
  logic            wd_hit;
  logic            err_set;

  function automatic logic wd_expired(input logic [WD_W-1:0] cnt);
    if (TIMEOUT == 0) return 1'b0;
    return cnt == WD_W'(TIMEOUT - 1);
  endfunction

  generate
    if (ADDR_WIDTH < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^cpu_addr[31:ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    in_xfer  = (state == WRITE) || (state == READ);
    // An acknowledge in the final watchdog cycle completes the transfer normally.
    wd_hit   = in_xfer && !ext_ack && wd_expired(wd_cnt);
    err_set  = ((state == IDLE) && mem_rd && mem_wr) ||
               (!in_xfer && ext_ack) ||
               wd_hit;
    mem_wait = ((state == IDLE) && mem_rd && !mem_wr) ||
               (state == READ) ||
               ((state == WRITE) && (mem_rd || mem_wr));
  end

  assign result_bus = (state == RDATA) ? rdata : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      rdata     <= '0;
      wd_cnt    <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (err_set)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_wr) begin
            state     <= WRITE;
            ext_req   <= 1'b1;
            ext_we    <= 1'b1;
            ext_addr  <= cpu_addr[ADDR_WIDTH-1:0];
            ext_wdata <= cpu_wdata;
            wd_cnt    <= '0;
          end else if (mem_rd) begin
            state    <= READ;
            ext_req  <= 1'b1;
            ext_we   <= 1'b0;
            ext_addr <= cpu_addr[ADDR_WIDTH-1:0];
            wd_cnt   <= '0;
          end
        end
        WRITE: begin
          if (ext_ack || wd_hit) begin
            state   <= IDLE;
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
          end
          if (!ext_ack) wd_cnt <= wd_cnt + WD_W'(1);
        end
        READ: begin
          if (ext_ack) begin
            state   <= RDATA;
            ext_req <= 1'b0;
            rdata   <= ext_rdata;
          end else if (wd_hit) begin
            state   <= RDATA;
            ext_req <= 1'b0;
            rdata   <= ERR_DATA;
          end
          if (!ext_ack) wd_cnt <= wd_cnt + WD_W'(1);
        end
        RDATA: state <= IDLE;
        default: begin
          state   <= IDLE;
          ext_req <= 1'b0;
          ext_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: transfer-level reference model checked every cycle,
// plus directed CPU read/write sequences with hand-computed expectations.
module tb_mem_bus_bridge;
  localparam int AW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic          err_clr = 1'b0;
  tri0  [31:0]   result_bus;
  logic          mem_wait;
  logic          bus_err;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic [31:0]   ext_rdata = '0;
  logic          ext_ack;

  int   slave_wait = 0;
  int   req_age = 0;
  logic stray_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_bus_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .result_bus(result_bus),
    .mem_wait(mem_wait), .bus_err(bus_err), .err_clr(err_clr),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  // Slave: acknowledges after slave_wait request cycles (-1 = never), plus injected strays.
  always @(posedge clk or negedge rst) begin
    if (!rst)                    req_age <= 0;
    else if (ext_req && !ext_ack) req_age <= req_age + 1;
    else                         req_age <= 0;
  end
  assign ext_ack = (ext_req && (req_age == slave_wait)) || stray_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model at transfer level: one outstanding bus transfer, one pending delivery.
  bit          m_busy = 0, m_we = 0, m_dlv = 0, m_err = 0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
  bit          req_we_q[$];

  always @(negedge clk) begin : cmp
    bit exp_wait, hit, evt;
    if (!rst) begin
      m_busy = 0; m_we = 0; m_dlv = 0; m_err = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_data = '0;
    end
    exp_wait = (!m_busy && !m_dlv && mem_rd && !mem_wr) ||
               (m_busy && (!m_we || mem_rd || mem_wr));
    chk("mdl_mem_wait", 32'(mem_wait), 32'(exp_wait));
    chk("mdl_ext_req", 32'(ext_req), 32'(m_busy));
    chk("mdl_bus_err", 32'(bus_err), 32'(m_err));
    chk("mdl_result_bus", result_bus, m_dlv ? m_data : 32'h0);
    if (m_busy) begin
      chk("mdl_ext_we", 32'(ext_we), 32'(m_we));
      chk("mdl_ext_addr", 32'(ext_addr), 32'(m_addr[AW-1:0]));
      if (m_we) chk("mdl_ext_wdata", ext_wdata, m_wdata);
      req_we_q.push_back(ext_we);
    end
    if (!rst) begin
      chk("mdl_rst_we", 32'(ext_we), 32'h0);
      chk("mdl_rst_addr", 32'(ext_addr), 32'h0);
      chk("mdl_rst_wdata", ext_wdata, 32'h0);
    end else begin
      hit = m_busy && !ext_ack && (TO != 0) && (m_age + 1 == TO);
      evt = (!m_busy && !m_dlv && mem_rd && mem_wr) || (!m_busy && ext_ack) || hit;
      if (evt)          m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_busy) begin
        if (ext_ack || hit) begin
          m_busy = 0;
          if (!m_we) begin
            m_dlv  = 1;
            m_data = ext_ack ? ext_rdata : 32'hFFFF_FFFF;
          end
        end else m_age++;
      end else if (m_dlv) begin
        m_dlv = 0;
      end else if (mem_wr || mem_rd) begin
        m_busy = 1; m_we = mem_wr; m_addr = cpu_addr; m_age = 0;
        if (mem_wr) m_wdata = cpu_wdata;
      end
    end
  end

  task automatic next_cycle(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) next_cycle(); endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int w);
    int n; bit done;
    w = 0; n = 0; done = 0;
    mem_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    while (!done && n < 50) begin
      mid();
      if (!mem_wait) done = 1;
      else begin w++; next_cycle(); end
      n++;
    end
    if (!done) chk("wr_stall_bound", 32'(done), 32'h1);
    next_cycle();
    mem_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int w);
    int n; bit done;
    w = 0; n = 0; done = 0; d = '0;
    mem_rd = 1'b1; cpu_addr = a;
    while (!done && n < 50) begin
      mid();
      if (!mem_wait) begin d = result_bus; done = 1; end
      else begin w++; next_cycle(); end
      n++;
    end
    if (!done) chk("rd_stall_bound", 32'(done), 32'h1);
    next_cycle();
    mem_rd = 1'b0;
  endtask

  task automatic clear_err();
    next_cycle(); err_clr = 1'b1;
    next_cycle(); err_clr = 1'b0;
  endtask

  initial begin
    int w, w2, s;
    logic [31:0] d;

    // Reset with a read strobe held.
    mem_rd = 1'b1; cpu_addr = 32'hABCD_0040; ext_rdata = 32'h2468_ACE0; slave_wait = 0;
    mid();
    chk("rst_ext_req", 32'(ext_req), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_result_bus", result_bus, 32'h0);
    chk("rst_mem_wait", 32'(mem_wait), 32'h1);
    next_cycle(); rst = 1'b1;
    next_cycle(); mid();
    chk("rst_first_req", 32'(ext_req), 32'h1);
    chk("rst_first_addr", 32'(ext_addr), 32'h0040);
    next_cycle(); mid();
    chk("rst_read_data", result_bus, 32'h2468_ACE0);
    chk("rst_read_wait", 32'(mem_wait), 32'h0);
    next_cycle(); mem_rd = 1'b0;
    idle(1);

    // Posted write, zero-wait slave.
    cpu_write(32'h0000_1234, 32'hCAFE_F00D, w);
    chk("wr_waits", 32'(w), 32'h0);
    mid();
    chk("wr_req", 32'(ext_req), 32'h1);
    chk("wr_we", 32'(ext_we), 32'h1);
    chk("wr_addr", 32'(ext_addr), 32'h1234);
    chk("wr_wdata", ext_wdata, 32'hCAFE_F00D);
    next_cycle(); mid();
    chk("wr_req_drop", 32'(ext_req), 32'h0);
    idle(1);

    // Read with three slave wait cycles; ack lands on the last watchdog cycle.
    slave_wait = 3; ext_rdata = 32'h1357_9BDF; s = req_we_q.size();
    cpu_read(32'h0000_0040, d, w);
    chk("rd_waits", 32'(w), 32'd5);
    chk("rd_data", d, 32'h1357_9BDF);
    chk("rd_req_cycles", 32'(req_we_q.size() - s), 32'd4);
    mid();
    chk("rd_bus_released", result_bus, 32'h0);
    chk("rd_ack_wins", 32'(bus_err), 32'h0);
    idle(1);

    // Back-to-back writes: the second is stalled one cycle.
    slave_wait = 0;
    cpu_write(32'h0000_0100, 32'h0000_00A1, w);
    cpu_write(32'h0000_0104, 32'h0000_00A2, w2);
    chk("b2b_first_waits", 32'(w), 32'h0);
    chk("b2b_second_waits", 32'(w2), 32'h1);
    idle(3);

    // Write immediately followed by a read.
    ext_rdata = 32'h0BAD_BEEF; s = req_we_q.size();
    cpu_write(32'h0000_2000, 32'h1111_2222, w);
    cpu_read(32'h0000_2004, d, w2);
    chk("wr_rd_waits", 32'(w2), 32'd3);
    chk("wr_rd_data", d, 32'h0BAD_BEEF);
    chk("wr_rd_xfers", 32'(req_we_q.size() - s), 32'd2);
    if (req_we_q.size() - s == 2) begin
      chk("wr_rd_we0", 32'(req_we_q[s]), 32'h1);
      chk("wr_rd_we1", 32'(req_we_q[s+1]), 32'h0);
    end
    idle(1);

    // Read timeout.
    slave_wait = -1; s = req_we_q.size();
    cpu_read(32'h0000_0080, d, w);
    chk("to_rd_waits", 32'(w), 32'd5);
    chk("to_rd_data", d, 32'hFFFF_FFFF);
    chk("to_rd_req_cycles", 32'(req_we_q.size() - s), 32'd4);
    mid();
    chk("to_rd_err", 32'(bus_err), 32'h1);
    clear_err(); mid();
    chk("to_rd_err_clr", 32'(bus_err), 32'h0);

    // Write timeout: the write is dropped.
    next_cycle(); s = req_we_q.size();
    cpu_write(32'h0000_0300, 32'h0000_55AA, w);
    chk("to_wr_waits", 32'(w), 32'h0);
    idle(5); mid();
    chk("to_wr_err", 32'(bus_err), 32'h1);
    chk("to_wr_req", 32'(ext_req), 32'h0);
    chk("to_wr_req_cycles", 32'(req_we_q.size() - s), 32'd4);
    clear_err(); slave_wait = 0;

    // Read and write together: performed as a write, flagged as an error.
    next_cycle();
    mem_rd = 1'b1; mem_wr = 1'b1; cpu_addr = 32'h0000_0500; cpu_wdata = 32'h0000_0077;
    mid();
    chk("rdwr_wait", 32'(mem_wait), 32'h0);
    next_cycle(); mem_rd = 1'b0; mem_wr = 1'b0; mid();
    chk("rdwr_req", 32'(ext_req), 32'h1);
    chk("rdwr_we", 32'(ext_we), 32'h1);
    chk("rdwr_wdata", ext_wdata, 32'h0000_0077);
    chk("rdwr_err", 32'(bus_err), 32'h1);
    clear_err(); mid();
    chk("rdwr_err_clr", 32'(bus_err), 32'h0);

    // Stray acknowledge in IDLE, then set-versus-clear priority.
    next_cycle(); stray_ack = 1'b1;
    next_cycle(); stray_ack = 1'b0; mid();
    chk("stray_err", 32'(bus_err), 32'h1);
    clear_err();
    stray_ack = 1'b1; err_clr = 1'b1;
    next_cycle(); stray_ack = 1'b0; err_clr = 1'b0; mid();
    chk("set_beats_clr", 32'(bus_err), 32'h1);
    clear_err();

    // Asynchronous reset during a hung read.
    slave_wait = -1;
    next_cycle(); mem_rd = 1'b1; cpu_addr = 32'h0000_0900;
    next_cycle(); next_cycle(); mid();
    chk("arst_pre_req", 32'(ext_req), 32'h1);
    next_cycle(); rst = 1'b0; mem_rd = 1'b0; #1;
    chk("arst_req", 32'(ext_req), 32'h0);
    chk("arst_addr", 32'(ext_addr), 32'h0);
    next_cycle(); rst = 1'b1; slave_wait = 0;
    idle(2); mid();
    chk("arst_idle_req", 32'(ext_req), 32'h0);
    chk("arst_idle_err", 32'(bus_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Bridge between the CPU's single-cycle memory strobes (`mem_rd`, `mem_wr`, address on `b_bus`, data on `result_bus`) and an external req/ack memory or MMIO slave. It sits directly downstream of the CPU core and posts writes through a one-entry write buffer. On reads it stalls the control unit via `mem_wait` until data returns, then drives the read data onto the shared tri-state `result_bus`. A timeout watchdog aborts hung transfers and records a sticky bus error.

## Interface
- `ADDR_WIDTH`, 16: external address width; `ext_addr = cpu_addr[ADDR_WIDTH-1:0]`.
- `TIMEOUT`, 255: cycles `ext_req` may stay high without `ext_ack` before abort; 0 disables the watchdog.
- `ERR_DATA`, 32'hFFFF_FFFF: data returned on an aborted read.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_addr` in 32: address, connected to CPU `b_bus`.
- `cpu_wdata` in 32: write data, connected to `result_bus`.
- `mem_rd` in 1: CPU read strobe, held until `mem_wait` is low at a clock edge.
- `mem_wr` in 1: CPU write strobe, held until `mem_wait` is low at a clock edge.
- `result_bus` inout 32 (tri): driven with read data only in state RDATA, else `'z`.
- `mem_wait` out 1: stall request to the CU (combinational).
- `bus_err` out 1: sticky error flag.
- `err_clr` in 1: synchronous clear of `bus_err`.
- `ext_req` out 1: external request (registered, Moore).
- `ext_we` out 1: external write enable, valid while `ext_req`.
- `ext_addr` out ADDR_WIDTH: external address (registered).
- `ext_wdata` out 32: external write data (registered).
- `ext_rdata` in 32: external read data, sampled on the `ext_ack` edge.
- `ext_ack` in 1: external completion, a single-cycle pulse; may be combinational from `ext_req`.

## Operation
- States: IDLE, WRITE, READ, RDATA.
- IDLE:
  - `mem_wr` → capture addr/data into the buffer, go to WRITE, `mem_wait=0` (write is posted).
  - `mem_rd` only → capture addr, go to READ, `mem_wait=1`.
  - `mem_rd && mem_wr` → treat as a write, set `bus_err`.
- WRITE:
  - `ext_req=1`, `ext_we=1`.
  - `ext_ack` → go to IDLE.
  - Any `mem_rd` or `mem_wr` while in WRITE → `mem_wait=1`. The CPU holds the request and it is accepted from IDLE on a later cycle.
- READ:
  - `ext_req=1`, `ext_we=0`.
  - `ext_ack` → `rdata <= ext_rdata`, go to RDATA.
- RDATA:
  - Drive `result_bus = rdata`, `mem_wait=0`.
  - Unconditionally go to IDLE.
- `mem_wait = (IDLE & mem_rd & ~mem_wr) | READ | (WRITE & (mem_rd | mem_wr))`.
- Watchdog: counter of width `$clog2(TIMEOUT+1)`.
  - Cleared on entry to WRITE or READ; increments each cycle in WRITE or READ without `ext_ack`.
  - On reaching `TIMEOUT` it sets `bus_err`. WRITE → IDLE (write dropped). READ → `rdata <= ERR_DATA`, go to RDATA.
  - `ext_ack` arriving in the same cycle as the timeout wins; no error is raised.
- `bus_err`: set has priority over `err_clr` in the same cycle.
- A stray `ext_ack` in IDLE or RDATA is ignored and sets `bus_err`.
- Reset (asynchronous assert):
  - Outputs: state IDLE; `ext_req=0`, `ext_we=0`, `ext_addr=0`, `ext_wdata=0`; `rdata=0`; `bus_err=0`; `result_bus='z`; watchdog counter 0.
  - A transfer in flight is abandoned; the slave must tolerate `ext_req` dropping.

## Timing
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata` are registered and change only on clock edges.
- `ext_req` rises the cycle after acceptance and falls the cycle after the edge that sampled `ext_ack`.
- Write, zero-wait slave:
  - CPU sees no stall.
  - `ext_req` high in cycle 1 only.
  - A back-to-back write in cycle 1 is stalled one cycle.
- Read, zero-wait slave:
  - Strobe in cycle 0; `mem_wait` high in cycles 0–1.
  - Data on `result_bus` in cycle 2; CPU latches at the end of cycle 2.
  - Each slave wait cycle adds one cycle.
- Read after posted write: the read waits for WRITE to complete and then takes the full read latency.
- `result_bus` is driven in exactly one cycle per read (RDATA) and never in any other state.

## Test plan
- Reset with `mem_rd=1` held → `ext_req=0`, `bus_err=0`, `result_bus='z`, `mem_wait=1`. Release reset → READ entered on the first edge.
- Write to addr 0x0000_1234, data 0xCAFE_F00D, ack same cycle:
  - `mem_wait` never high.
  - `ext_req` and `ext_we` high for 1 cycle with `ext_addr=0x1234`, `ext_wdata=0xCAFE_F00D`.
- Read from 0x40, slave acks after 3 wait cycles with 0x1357_9BDF:
  - `mem_wait` high for 5 cycles.
  - `result_bus=0x1357_9BDF` for one cycle, then `'z`.
- Write immediately followed by a read: read stalled during WRITE; `ext_we` is 1 then 0 on consecutive transfers; read data correct.
- Slave never acks, `TIMEOUT=4`, read:
  - Abort after 4 request cycles; `result_bus=0xFFFF_FFFF`; `bus_err=1`.
  - `err_clr` pulse → `bus_err=0`.
- `mem_rd` and `mem_wr` asserted together, then a stray `ext_ack` in IDLE → write performed; `bus_err` set on both events.
